// File: rtl/keypad_pkg.sv
// Shared keypad types: key map, key code type and decoder result struct.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef logic [3:0] keycode_t;

  typedef struct packed {
    logic     ok;
    keycode_t code;
  } dec_t;

  // Indexed [row][col]; col0 is the leftmost entry of each row.
  localparam keycode_t KEYMAP [NUM_ROWS][NUM_COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

endpackage

// File: rtl/key_decode.sv
// Combinational key decoder: active row plus active-low column bus -> {ok, hex code}.
module key_decode
  import keypad_pkg::*;
(
  input  logic [1:0] row_idx_i,
  input  logic [3:0] cols_i,
  output dec_t       dec_o
);

  logic [1:0] col;
  logic       one_low;

  // Only a single low column is a clean press; anything else is ghosting or bounce.
  always_comb begin
    col     = 2'd0;
    one_low = 1'b1;
    case (cols_i)
      4'b1110: col = 2'd0;
      4'b1101: col = 2'd1;
      4'b1011: col = 2'd2;
      4'b0111: col = 2'd3;
      default: one_low = 1'b0;
    endcase
    dec_o.ok   = one_low;
    dec_o.code = one_low ? KEYMAP[row_idx_i][col] : 4'h0;
  end

endmodule

// File: rtl/key_event_fifo.sv
// Keypad press queue: decodes scanner strobes and buffers hex codes for a valid/ready consumer.
// Optional macro DROP_OLDEST_EN: a push into a full queue evicts the oldest code instead of being dropped.
module key_event_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       key_pulse,
  input  logic [1:0]                 row_idx,
  input  logic [3:0]                 cols,
  input  logic                       out_ready,
  input  logic                       clr_ovf,
  output logic                       out_valid,
  output logic [3:0]                 out_code,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       bad_press
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  dec_t              dec;
  keycode_t          mem_q [DEPTH];
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     count_q, count_d;
  keycode_t          code_q, code_d;
  logic              ovf_q, ovf_d, bad_q;
  logic              push, pop, full, ovf_evt, wr_en, rd_adv;

  key_decode u_dec (
    .row_idx_i (row_idx),
    .cols_i    (cols),
    .dec_o     (dec)
  );

  assign full    = (count_q == CW'(DEPTH));
  assign push    = key_pulse & dec.ok;
  assign pop     = (count_q != '0) & out_ready;
  assign ovf_evt = push & full & ~pop;

`ifdef DROP_OLDEST_EN
  assign wr_en  = push;
  assign rd_adv = pop | ovf_evt;
`else
  assign wr_en  = push & (~full | pop);
  assign rd_adv = pop;
`endif

  always_comb begin
    rd_d    = rd_adv ? rd_q + PW'(1) : rd_q;
    wr_d    = wr_en  ? wr_q + PW'(1) : wr_q;
    count_d = count_q;
    if (wr_en && !rd_adv)      count_d = count_q + CW'(1);
    else if (rd_adv && !wr_en) count_d = count_q - CW'(1);
    // Head register tracks the entry at the new read pointer; bypass when it is being written now.
    code_d = code_q;
    if (count_d != '0)
      code_d = (wr_en && (wr_q == rd_d)) ? dec.code : mem_q[rd_d];
    ovf_d = ovf_evt | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      if (wr_en) mem_q[wr_q] <= dec.code;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
      bad_q   <= key_pulse & ~dec.ok;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_code  = code_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign bad_press = bad_q;

endmodule

// File: tb/tb_key_event_fifo.sv
// Directed self-checking bench for key_event_fifo (DEPTH=4), both full-queue policies.
module tb_key_event_fifo;

  logic       clk = 1'b0;
  logic       reset, key_pulse, out_ready, clr_ovf;
  logic [1:0] row_idx;
  logic [3:0] cols;
  logic       out_valid, overflow, bad_press;
  logic [3:0] out_code;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q [4];

  key_event_fifo #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_pulse (key_pulse),
    .row_idx   (row_idx),
    .cols      (cols),
    .out_ready (out_ready),
    .clr_ovf   (clr_ovf),
    .out_valid (out_valid),
    .out_code  (out_code),
    .count     (count),
    .overflow  (overflow),
    .bad_press (bad_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one strobe for a single cycle; returns at the following negedge.
  task automatic press(input logic [1:0] r, input logic [3:0] c, input logic rdy);
    key_pulse = 1'b1; row_idx = r; cols = c; out_ready = rdy;
    @(negedge clk);
    key_pulse = 1'b0; cols = 4'hF; out_ready = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; key_pulse = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    row_idx = 2'd0; cols = 4'hF;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_count", count, 3'd0);
    check("rst_ovf",   overflow, 1'b0);
    check("rst_bad",   bad_press, 1'b0);
    check("rst_code",  out_code, 4'h0);
    reset = 1'b1;
    @(negedge clk);

    // Decode row 2 col 1 -> 8, one-cycle latency
    press(2'd2, 4'b1101, 1'b0);
    check("dec_valid", out_valid, 1'b1);
    check("dec_code",  out_code, 4'h8);
    check("dec_count", count, 3'd1);
    pop1();
    check("drain_valid", out_valid, 1'b0);
    check("drain_hold",  out_code, 4'h8);
    pop1();
    check("empty_ready_ignored", count, 3'd0);

    // Ordering: 1,5,9,0
    press(2'd0, 4'b1110, 1'b0);
    check("ord_head1", out_code, 4'h1);
    press(2'd1, 4'b1101, 1'b0);
    press(2'd2, 4'b1011, 1'b0);
    press(2'd3, 4'b1101, 1'b0);
    check("ord_count4", count, 3'd4);
    check("ord_head",   out_code, 4'h1);
    check("ord_ovf0",   overflow, 1'b0);

    // Push A into full queue
    press(2'd0, 4'b0111, 1'b0);
    check("full_count", count, 3'd4);
    check("full_ovf",   overflow, 1'b1);
`ifdef DROP_OLDEST_EN
    check("full_head", out_code, 4'h5);
`else
    check("full_head", out_code, 4'h1);
`endif
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("clr_ovf", overflow, 1'b0);

    // Full push of B with simultaneous pop
    press(2'd1, 4'b0111, 1'b1);
    check("pp_count", count, 3'd4);
    check("pp_ovf",   overflow, 1'b0);
`ifdef DROP_OLDEST_EN
    exp_q = '{4'h9, 4'h0, 4'hA, 4'hB};
`else
    exp_q = '{4'h5, 4'h9, 4'h0, 4'hB};
`endif
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_code%0d", i), out_code, exp_q[i]);
      pop1();
    end
    check("drain_empty", out_valid, 1'b0);
    check("drain_last",  out_code, 4'hB);

    // Bad presses: two lows, then none
    press(2'd1, 4'b1001, 1'b0);
    check("bad2_pulse", bad_press, 1'b1);
    check("bad2_count", count, 3'd0);
    @(negedge clk);
    check("bad2_clear", bad_press, 1'b0);
    press(2'd3, 4'b1111, 1'b0);
    check("bad0_pulse", bad_press, 1'b1);
    check("bad0_count", count, 3'd0);
    check("bad0_code",  out_code, 4'hB);
    @(negedge clk);
    check("bad0_clear", bad_press, 1'b0);

    // Async reset mid-stream with 3 queued
    press(2'd0, 4'b1101, 1'b0);
    press(2'd1, 4'b1110, 1'b0);
    press(2'd2, 4'b1110, 1'b0);
    check("pre_rst_count", count, 3'd3);
    check("pre_rst_head",  out_code, 4'h2);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_count", count, 3'd0);
    check("mid_rst_ovf",   overflow, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    press(2'd3, 4'b1110, 1'b0);
    check("post_rst_code",  out_code, 4'hE);
    check("post_rst_count", count, 3'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
